// File: rtl/irrigation_zone_scheduler.sv
// ============================================================================
// Module   : irrigation_zone_scheduler
// Purpose  : Round-robin multi-zone valve scheduler with timed runs and gaps.
//            Optional rain lockout is enabled by defining RAIN_LOCKOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module irrigation_zone_scheduler #(
  parameter int ZONES           = 4,
  parameter int TIMER_W         = 16,
  parameter int SPRINKLER_TICKS = 10,
  parameter int DRIP_TICKS      = 30,
  parameter int GAP_TICKS       = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       aut,
  input  logic [ZONES-1:0]           sprinkler_req,
  input  logic [ZONES-1:0]           drip_req,
  input  logic                       manual_on,
  input  logic [$clog2(ZONES)-1:0]   manual_zone,
`ifdef RAIN_LOCKOUT_EN
  input  logic                       rain,
  output logic                       locked,
`endif
  output logic [ZONES-1:0]           valve_en,
  output logic [1:0]                 mode_code,
  output logic [$clog2(ZONES)-1:0]   active_zone,
  output logic                       busy,
  output logic                       zone_done,
  output logic [ZONES-1:0]           conflict
);

  localparam int ZW = $clog2(ZONES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_MANUAL = 3'd4;

  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_SPR  = 2'b01;
  localparam logic [1:0] M_DRIP = 2'b10;
  localparam logic [1:0] M_MAN  = 2'b11;

  localparam logic [ZONES-1:0] c_one = {{(ZONES-1){1'b0}}, 1'b1};

  logic [2:0]         r_state, w_state_n;
  logic [TIMER_W-1:0] r_timer;
  logic [1:0]         r_mode;
  logic [ZW-1:0]      r_last_grant, r_zone;
  logic [ZONES-1:0]   r_valve_en, r_conflict, w_valve_n, w_elig;
  logic [1:0]         r_mode_code, w_mode_n, w_sel_mode;
  logic               r_busy, r_zone_done, w_busy_n, w_done_n;
  logic               w_found, w_served_ok, w_run_done, w_rain, w_man_ok;
  logic [ZW-1:0]      w_sel_idx;
  int                 w_rr_idx;

`ifdef RAIN_LOCKOUT_EN
  logic r_locked;
  assign w_rain = rain;
  assign locked = r_locked;
`else
  assign w_rain = 1'b0;
`endif

  assign w_elig      = sprinkler_req ^ drip_req;
  assign w_sel_mode  = sprinkler_req[w_sel_idx] ? M_SPR : M_DRIP;
  // The served zone must still request the exact mode it was granted with.
  assign w_served_ok = (r_mode == M_SPR) ? (sprinkler_req[r_zone] & ~drip_req[r_zone])
                                         : (drip_req[r_zone] & ~sprinkler_req[r_zone]);
  assign w_run_done  = tick && (r_timer == TIMER_W'(1));
  assign w_man_ok    = manual_on && (int'(manual_zone) < ZONES);

  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_rr_idx  = 0;
    for (int k = 1; k <= ZONES; k++) begin
      w_rr_idx = (int'(r_last_grant) + k) % ZONES;
      if (!w_found && w_elig[w_rr_idx]) begin
        w_found   = 1'b1;
        w_sel_idx = ZW'(w_rr_idx);
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: begin
        if (!aut)                      w_state_n = S_MANUAL;
        else if (|w_elig && !w_rain)   w_state_n = S_SELECT;
      end
      S_SELECT: begin
        if (!aut)                      w_state_n = S_MANUAL;
        else if (w_rain || !w_found)   w_state_n = S_IDLE;
        else                           w_state_n = S_RUN;
      end
      S_RUN: begin
        if (!aut)                      w_state_n = S_MANUAL;
        else if (w_rain)               w_state_n = S_IDLE;
        else if (!w_served_ok)         w_state_n = S_GAP;
        else if (w_run_done)           w_state_n = S_GAP;
      end
      S_GAP: begin
        if (w_rain || r_timer == '0)   w_state_n = S_IDLE;
      end
      S_MANUAL: begin
        if (aut)                       w_state_n = S_IDLE;
      end
      default:                         w_state_n = S_IDLE;
    endcase
  end

  // Output values are computed for the upcoming state so every output is a register.
  always_comb begin
    w_valve_n = '0;
    w_mode_n  = M_IDLE;
    w_busy_n  = (w_state_n == S_SELECT) || (w_state_n == S_RUN) || (w_state_n == S_GAP);
    w_done_n  = (r_state == S_RUN) && (w_state_n == S_GAP) && w_served_ok && w_run_done;
    if (w_state_n == S_RUN) begin
      w_valve_n = c_one << ((r_state == S_SELECT) ? w_sel_idx : r_zone);
      w_mode_n  = (r_state == S_SELECT) ? w_sel_mode : r_mode;
    end else if (w_state_n == S_MANUAL) begin
      w_mode_n = M_MAN;
      if (r_state == S_MANUAL && w_man_ok) w_valve_n = c_one << manual_zone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_mode       <= M_IDLE;
      r_last_grant <= ZW'(ZONES - 1);
      r_zone       <= '0;
      r_valve_en   <= '0;
      r_mode_code  <= M_IDLE;
      r_busy       <= 1'b0;
      r_zone_done  <= 1'b0;
      r_conflict   <= '0;
`ifdef RAIN_LOCKOUT_EN
      r_locked     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_valve_en  <= w_valve_n;
      r_mode_code <= w_mode_n;
      r_busy      <= w_busy_n;
      r_zone_done <= w_done_n;
      r_conflict  <= sprinkler_req & drip_req;
`ifdef RAIN_LOCKOUT_EN
      r_locked    <= rain & aut;
`endif
      case (r_state)
        S_SELECT: begin
          if (w_state_n == S_RUN) begin
            r_zone       <= w_sel_idx;
            r_last_grant <= w_sel_idx;
            r_mode       <= w_sel_mode;
            r_timer      <= (w_sel_mode == M_SPR) ? TIMER_W'(SPRINKLER_TICKS)
                                                  : TIMER_W'(DRIP_TICKS);
          end
        end
        S_RUN: begin
          if (w_state_n != S_RUN)            r_timer <= TIMER_W'(GAP_TICKS);
          else if (tick && r_timer != '0)    r_timer <= r_timer - TIMER_W'(1);
        end
        S_GAP: begin
          if (tick && r_timer != '0)         r_timer <= r_timer - TIMER_W'(1);
        end
        default: ;
      endcase
      if (w_state_n == S_MANUAL) r_zone <= manual_zone;
    end
  end

  assign valve_en    = r_valve_en;
  assign mode_code   = r_mode_code;
  assign active_zone = r_zone;
  assign busy        = r_busy;
  assign zone_done   = r_zone_done;
  assign conflict    = r_conflict;

endmodule

`default_nettype wire

// File: tb/tb_irrigation_zone_scheduler.sv
// ============================================================================
// Module   : tb_irrigation_zone_scheduler
// Purpose  : Directed self-checking bench for irrigation_zone_scheduler.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_irrigation_zone_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       aut = 1'b1;
  logic       manual_on = 1'b0;
  logic [3:0] spr = 4'b0;
  logic [3:0] drip = 4'b0;
  logic [1:0] mz = 2'd0;
  logic [3:0] valve_en, conflict;
  logic [1:0] mode_code, active_zone;
  logic       busy, zone_done;

  // Second instance with a non-power-of-two zone count for the out-of-range manual index.
  logic       aut3 = 1'b0;
  logic       man3 = 1'b1;
  logic [1:0] mz3 = 2'd3;
  logic [2:0] req3_s = 3'b0;
  logic [2:0] req3_d = 3'b0;
  logic [2:0] v3, c3;
  logic [1:0] m3, az3;
  logic       b3, zd3;

`ifdef RAIN_LOCKOUT_EN
  logic rain = 1'b0;
  logic locked;
  logic rain3 = 1'b0;
  logic locked3;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irrigation_zone_scheduler #(.ZONES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .aut(aut),
    .sprinkler_req(spr), .drip_req(drip),
    .manual_on(manual_on), .manual_zone(mz),
`ifdef RAIN_LOCKOUT_EN
    .rain(rain), .locked(locked),
`endif
    .valve_en(valve_en), .mode_code(mode_code), .active_zone(active_zone),
    .busy(busy), .zone_done(zone_done), .conflict(conflict)
  );

  irrigation_zone_scheduler #(.ZONES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .tick(1'b0), .aut(aut3),
    .sprinkler_req(req3_s), .drip_req(req3_d),
    .manual_on(man3), .manual_zone(mz3),
`ifdef RAIN_LOCKOUT_EN
    .rain(rain3), .locked(locked3),
`endif
    .valve_en(v3), .mode_code(m3), .active_zone(az3),
    .busy(b3), .zone_done(zd3), .conflict(c3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("onehot0", 32'($onehot0(valve_en)), 32'd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse_tick();
  endtask

  initial begin
    step(); step();
    check("rst_valve", valve_en, 4'b0000);
    check("rst_mode", mode_code, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", zone_done, 1'b0);
    check("rst_conflict", conflict, 4'b0000);
    check("rst_zone", active_zone, 2'd0);
    rst_n = 1'b1;
    step(); step(); step();
    check("idle_busy", busy, 1'b0);
    check("idle_mode", mode_code, 2'b00);

    // Sprinkler run on zone 0
    spr = 4'b0001;
    step();
    check("sel_busy", busy, 1'b1);
    check("sel_valve", valve_en, 4'b0000);
    step();
    check("spr_valve", valve_en, 4'b0001);
    check("spr_mode", mode_code, 2'b01);
    check("spr_zone", active_zone, 2'd0);
    ticks(9);
    check("spr_9_valve", valve_en, 4'b0001);
    check("spr_9_done", zone_done, 1'b0);
    pulse_tick();
    check("spr_done", zone_done, 1'b1);
    check("spr_close", valve_en, 4'b0000);
    check("gap_mode", mode_code, 2'b00);
    check("gap_busy", busy, 1'b1);
    spr = 4'b0000;
    step();
    check("done_pulse", zone_done, 1'b0);
    ticks(2);
    check("gap_hold", busy, 1'b1);
    step();
    check("gap_exit", busy, 1'b0);

    // Drip round-robin over zones 1 and 2
    drip = 4'b0110;
    step(); step();
    check("drip1_valve", valve_en, 4'b0010);
    check("drip1_mode", mode_code, 2'b10);
    check("drip1_zone", active_zone, 2'd1);
    ticks(29);
    check("drip1_29_done", zone_done, 1'b0);
    pulse_tick();
    check("drip1_done", zone_done, 1'b1);
    ticks(2); step(); step(); step();
    check("drip2_valve", valve_en, 4'b0100);
    check("drip2_zone", active_zone, 2'd2);
    ticks(30);
    check("drip2_done", zone_done, 1'b1);
    ticks(2); step(); step(); step();
    check("rr_back_z1", valve_en, 4'b0010);

    // Manual override mid-run
    ticks(3);
    aut = 1'b0; manual_on = 1'b1; mz = 2'd2;
    step();
    check("abort_off", valve_en, 4'b0000);
    check("abort_done", zone_done, 1'b0);
    check("abort_busy", busy, 1'b0);
    step();
    check("man_valve", valve_en, 4'b0100);
    check("man_mode", mode_code, 2'b11);
    check("man_zone", active_zone, 2'd2);
    check("man_done", zone_done, 1'b0);
    manual_on = 1'b0;
    step();
    check("man_off", valve_en, 4'b0000);
    drip = 4'b0000; aut = 1'b1;
    step();
    check("man_exit_mode", mode_code, 2'b00);

    // Conflict on zone 3, pointer preserved through manual mode
    spr = 4'b1000; drip = 4'b1000;
    step();
    check("conflict", conflict, 4'b1000);
    step(); step();
    check("conflict_valve", valve_en, 4'b0000);
    check("conflict_busy", busy, 1'b0);
    spr = 4'b1101;
    step(); step();
    check("rr_preserved", valve_en, 4'b0100);
    check("rr_pres_mode", mode_code, 2'b01);
    spr = 4'b1001;
    step();
    check("drop_abort", valve_en, 4'b0000);
    check("drop_no_done", zone_done, 1'b0);
    check("drop_gap_busy", busy, 1'b1);
    ticks(2); step(); step(); step();
    check("skip_conflict", valve_en, 4'b0001);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    check("async_valve", valve_en, 4'b0000);
    check("async_busy", busy, 1'b0);
    check("async_done", zone_done, 1'b0);
    #2 rst_n = 1'b1;
    spr = 4'b0000; drip = 4'b0000;
    step(); step();

`ifdef RAIN_LOCKOUT_EN
    drip = 4'b0001;
    step(); step();
    check("rain_run", valve_en, 4'b0001);
    ticks(3);
    rain = 1'b1;
    step();
    check("rain_off", valve_en, 4'b0000);
    check("rain_locked", locked, 1'b1);
    check("rain_done", zone_done, 1'b0);
    step(); step();
    check("rain_hold", busy, 1'b0);
    rain = 1'b0;
    step(); step();
    check("rain_resume", valve_en, 4'b0001);
    check("rain_unlock", locked, 1'b0);
    drip = 4'b0000;
`endif

    // Manual index beyond the zone count on the 3-zone instance
    mz3 = 2'd3;
    step(); step();
    check("oor_valve", v3, 3'b000);
    check("oor_mode", m3, 2'b11);
    mz3 = 2'd2;
    step();
    check("z3_man_valve", v3, 3'b100);
    check("z3_man_zone", az3, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
